// File: rtl/acumulador_param.sv
// Coin-credit accumulator for a vending machine: accepts coins, vends, refunds.
// Optional inactivity refund is compiled in when ACUMULADOR_TIMEOUT_EN is defined.
module acumulador_param #(
    parameter int W              = 8,
    parameter int MAX_CREDIT     = 8,
    parameter int VAL1           = 1,
    parameter int VAL2           = 2,
    parameter int VAL3           = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   valorMoeda,
    input  logic         moedaValida,
    input  logic [W-1:0] preco,
    input  logic         compra,
    input  logic         cancela,
    output logic [W-1:0] valorAcumulado,
    output logic         liberaProduto,
    output logic [W-1:0] troco,
    output logic         trocoValido,
    output logic         moedaRejeitada,
    output logic         tempoEsgotado
);

    if (TIMEOUT_CYCLES < 2 || MAX_CREDIT >= (1 << W)) begin : g_bad_params
        $error("acumulador_param: illegal TIMEOUT_CYCLES or MAX_CREDIT");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACUM   = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    localparam logic [W:0] V1    = (W+1)'(VAL1);
    localparam logic [W:0] V2    = (W+1)'(VAL2);
    localparam logic [W:0] V3    = (W+1)'(VAL3);
    localparam logic [W:0] MAX_C = (W+1)'(MAX_CREDIT);

    state_t         state_q, state_d;
    logic [W-1:0]   credit_q, credit_d;
    logic [W-1:0]   troco_q, troco_d;
    logic           libera_q, libera_d;
    logic           troco_valido_q, troco_valido_d;
    logic           rejeitada_q, rejeitada_d;
    logic           esgotado_q, esgotado_d;

    logic [W:0]     coin_val;
    logic [W:0]     coin_sum;
    logic           coin_present;
    logic           coin_fits;
    logic           buy_ok;
    logic           timeout_hit;

`ifdef ACUMULADOR_TIMEOUT_EN
    localparam int            CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        case (valorMoeda)
            2'b01:   coin_val = V1;
            2'b10:   coin_val = V2;
            2'b11:   coin_val = V3;
            default: coin_val = '0;
        endcase
    end

    assign coin_present = moedaValida && (valorMoeda != 2'b00);
    assign coin_sum     = {1'b0, credit_q} + coin_val;
    assign coin_fits    = (coin_sum <= MAX_C);
    assign buy_ok       = (credit_q >= preco);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        troco_d        = '0;
        libera_d       = 1'b0;
        troco_valido_d = 1'b0;
        rejeitada_d    = 1'b0;
        esgotado_d     = 1'b0;
`ifdef ACUMULADOR_TIMEOUT_EN
        cnt_d          = '0;
`endif
        case (state_q)
            IDLE: begin
                if (coin_present) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[W-1:0];
                        state_d  = ACUM;
                    end else begin
                        rejeitada_d = 1'b1;
                    end
                end
            end
            ACUM: begin
                // Priority: cancela > effective compra > coin > timeout.
                // An underfunded compra does not block a coin in the same cycle.
                if (cancela) begin
                    state_d        = REFUND;
                    troco_d        = credit_q;
                    troco_valido_d = 1'b1;
                    credit_d       = '0;
                    rejeitada_d    = coin_present;
                end else if (compra && buy_ok) begin
                    state_d        = VEND;
                    troco_d        = credit_q - preco;
                    troco_valido_d = 1'b1;
                    libera_d       = 1'b1;
                    credit_d       = '0;
                    rejeitada_d    = coin_present;
                end else if (coin_present && coin_fits) begin
                    credit_d = coin_sum[W-1:0];
                end else begin
                    rejeitada_d = coin_present;
                    if (timeout_hit) begin
                        state_d        = REFUND;
                        troco_d        = credit_q;
                        troco_valido_d = 1'b1;
                        esgotado_d     = 1'b1;
                        credit_d       = '0;
                    end else begin
`ifdef ACUMULADOR_TIMEOUT_EN
                        cnt_d = cnt_q + CW'(1);
`endif
                    end
                end
            end
            VEND, REFUND: begin
                state_d     = IDLE;
                credit_d    = '0;
                rejeitada_d = coin_present;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            troco_q        <= '0;
            libera_q       <= 1'b0;
            troco_valido_q <= 1'b0;
            rejeitada_q    <= 1'b0;
            esgotado_q     <= 1'b0;
`ifdef ACUMULADOR_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            troco_q        <= troco_d;
            libera_q       <= libera_d;
            troco_valido_q <= troco_valido_d;
            rejeitada_q    <= rejeitada_d;
            esgotado_q     <= esgotado_d;
`ifdef ACUMULADOR_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign valorAcumulado = credit_q;
    assign troco          = troco_q;
    assign liberaProduto  = libera_q;
    assign trocoValido    = troco_valido_q;
    assign moedaRejeitada = rejeitada_q;
    assign tempoEsgotado  = esgotado_q;

endmodule

// File: tb/tb_acumulador_param.sv
// Directed self-checking bench for acumulador_param (W=8, MAX_CREDIT=8, VAL 1/2/4, TIMEOUT_CYCLES=16).
module tb_acumulador_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] valorMoeda;
    logic       moedaValida;
    logic [7:0] preco;
    logic       compra;
    logic       cancela;
    logic [7:0] valorAcumulado;
    logic       liberaProduto;
    logic [7:0] troco;
    logic       trocoValido;
    logic       moedaRejeitada;
    logic       tempoEsgotado;

    logic [3:0] pulses;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    acumulador_param #(
        .W              (8),
        .MAX_CREDIT     (8),
        .VAL1           (1),
        .VAL2           (2),
        .VAL3           (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valorMoeda     (valorMoeda),
        .moedaValida    (moedaValida),
        .preco          (preco),
        .compra         (compra),
        .cancela        (cancela),
        .valorAcumulado (valorAcumulado),
        .liberaProduto  (liberaProduto),
        .troco          (troco),
        .trocoValido    (trocoValido),
        .moedaRejeitada (moedaRejeitada),
        .tempoEsgotado  (tempoEsgotado)
    );

    always #5 clk = ~clk;

    // {liberaProduto, trocoValido, moedaRejeitada, tempoEsgotado}
    assign pulses = {liberaProduto, trocoValido, moedaRejeitada, tempoEsgotado};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code);
        moedaValida = 1'b1;
        valorMoeda  = code;
        step();
        moedaValida = 1'b0;
        valorMoeda  = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic early;
        logic found;
        reset       = 1'b0;
        valorMoeda  = 2'b00;
        moedaValida = 1'b0;
        preco       = 8'd0;
        compra      = 1'b0;
        cancela     = 1'b0;
        #1;
        check("reset_credit", 32'(valorAcumulado), 32'd0);
        check("reset_troco", 32'(troco), 32'd0);
        check("reset_pulses", 32'(pulses), 32'd0);
        step();
        step();
        reset = 1'b1;

        // Coin accumulation 1, 3, 7 then over-limit rejection
        put_coin(2'b01);
        check("coin01_credit", 32'(valorAcumulado), 32'd1);
        put_coin(2'b10);
        check("coin10_credit", 32'(valorAcumulado), 32'd3);
        put_coin(2'b11);
        check("coin11_credit", 32'(valorAcumulado), 32'd7);
        put_coin(2'b10);
        check("over_rej", 32'(moedaRejeitada), 32'd1);
        check("over_credit", 32'(valorAcumulado), 32'd7);
        step();
        check("rej_one_cycle", 32'(pulses), 32'd0);

        // Code 00 with strobe is ignored
        put_coin(2'b00);
        check("code00_pulses", 32'(pulses), 32'd0);
        check("code00_credit", 32'(valorAcumulado), 32'd7);

        // Vend at credit 7, price 6; coin during VEND rejected
        preco  = 8'd6;
        compra = 1'b1;
        step();
        compra = 1'b0;
        check("vend_pulses", 32'(pulses), 32'b1100);
        check("vend_troco", 32'(troco), 32'd1);
        put_coin(2'b01);
        check("vend_coin_rej", 32'(moedaRejeitada), 32'd1);
        check("vend_after_credit", 32'(valorAcumulado), 32'd0);
        check("vend_after_troco", 32'(troco), 32'd0);
        check("vend_after_tv", 32'(trocoValido), 32'd0);

        // compra/cancela in IDLE are ignored
        preco   = 8'd0;
        compra  = 1'b1;
        cancela = 1'b1;
        step();
        compra  = 1'b0;
        cancela = 1'b0;
        check("idle_cmds_pulses", 32'(pulses), 32'd0);
        check("idle_cmds_credit", 32'(valorAcumulado), 32'd0);

        // Underfunded compra ignored, then cancela refunds 3
        put_coin(2'b01);
        put_coin(2'b10);
        preco  = 8'd6;
        compra = 1'b1;
        step();
        compra = 1'b0;
        check("poor_pulses", 32'(pulses), 32'd0);
        check("poor_credit", 32'(valorAcumulado), 32'd3);
        cancela = 1'b1;
        step();
        cancela = 1'b0;
        check("cancel_pulses", 32'(pulses), 32'b0100);
        check("cancel_troco", 32'(troco), 32'd3);
        step();
        check("cancel_after_credit", 32'(valorAcumulado), 32'd0);

        // cancela + compra + coin together at credit 2
        put_coin(2'b10);
        check("prio_credit", 32'(valorAcumulado), 32'd2);
        cancela     = 1'b1;
        compra      = 1'b1;
        preco       = 8'd1;
        moedaValida = 1'b1;
        valorMoeda  = 2'b01;
        step();
        cancela     = 1'b0;
        compra      = 1'b0;
        moedaValida = 1'b0;
        valorMoeda  = 2'b00;
        check("prio_pulses", 32'(pulses), 32'b0110);
        check("prio_troco", 32'(troco), 32'd2);
        step();

        // Inactivity refund at credit 4
        put_coin(2'b11);
        check("to_credit", 32'(valorAcumulado), 32'd4);
        early = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (tempoEsgotado || trocoValido) early = 1'b1;
        end
        check("to_no_early", 32'(early), 32'd0);
        check("to_hold_credit", 32'(valorAcumulado), 32'd4);
`ifdef ACUMULADOR_TIMEOUT_EN
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step();
            if (tempoEsgotado) found = 1'b1;
        end
        check("to_fired", 32'(found), 32'd1);
        check("to_pulses", 32'(pulses), 32'b0101);
        check("to_troco", 32'(troco), 32'd4);
        step();
        check("to_after_credit", 32'(valorAcumulado), 32'd0);
`else
        found = 1'b0;
        for (int i = 0; i < 86; i++) begin
            step();
            if (tempoEsgotado || trocoValido) found = 1'b1;
        end
        check("noto_no_pulse", 32'(found), 32'd0);
        check("noto_credit", 32'(valorAcumulado), 32'd4);
        cancela = 1'b1;
        step();
        cancela = 1'b0;
        check("noto_cancel_troco", 32'(troco), 32'd4);
        step();
`endif

        // Exact-limit credit 8, over-limit coin, vend with zero change, reset mid-VEND
        put_coin(2'b11);
        put_coin(2'b11);
        check("max_credit", 32'(valorAcumulado), 32'd8);
        put_coin(2'b01);
        check("max_rej", 32'(moedaRejeitada), 32'd1);
        check("max_hold", 32'(valorAcumulado), 32'd8);
        preco  = 8'd8;
        compra = 1'b1;
        step();
        compra = 1'b0;
        check("vend0_pulses", 32'(pulses), 32'b1100);
        check("vend0_troco", 32'(troco), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pulses", 32'(pulses), 32'd0);
        check("async_rst_credit", 32'(valorAcumulado), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_credit", 32'(valorAcumulado), 32'd0);
        step();
        check("post_rst_pulses2", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acumulador_param.md
ACUMULADOR_PARAM -- requirements
Module: acumulador_param

Interface
REQ-001 SHALL have parameter W, 8, accumulator width in units of R$0,25.
REQ-002 SHALL have parameter MAX_CREDIT, 8, maximum credit in units (8 = R$2,00); must be < 2^W.
REQ-003 SHALL have parameters VAL1, VAL2, VAL3, defaults 1, 2, 4, unit values of coin codes 01, 10, 11.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles; must be >= 2.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 valorMoeda  input  2  coin code; 00 = no coin.
REQ-008 moedaValida  input  1  one-cycle strobe qualifying valorMoeda.
REQ-009 preco  input  W  product price in units, sampled with compra.
REQ-010 compra  input  1  purchase request strobe.
REQ-011 cancela  input  1  cancel/refund request strobe.
REQ-012 valorAcumulado  output  W  current credit, registered.
REQ-013 liberaProduto  output  1  one-cycle vend pulse.
REQ-014 troco  output  W  change amount, valid only with trocoValido.
REQ-015 trocoValido  output  1  one-cycle change pulse.
REQ-016 moedaRejeitada  output  1  one-cycle pulse, coin not accepted.
REQ-017 tempoEsgotado  output  1  one-cycle pulse, inactivity refund started.

Function
REQ-018 SHALL implement FSM states IDLE, ACUM, VEND, REFUND; illegal encodings SHALL go to IDLE next cycle.
REQ-019 Coin accepted when moedaValida=1, code != 00, state IDLE/ACUM, credit+value <= MAX_CREDIT; sum computed in W+1 bits.
REQ-020 Accepted coin: valorAcumulado updates at that edge (visible next cycle); IDLE -> ACUM.
REQ-021 Coin over MAX_CREDIT, or any coin in VEND/REFUND: moedaRejeitada=1 next cycle, credit unchanged.
REQ-022 moedaValida with code 00: ignored, no pulse.
REQ-023 ACUM priority per cycle: cancela > compra > coin > timeout; lower-priority coin in same cycle is rejected (REQ-021).
REQ-024 ACUM + cancela -> REFUND.
REQ-025 ACUM + compra with credit >= preco -> VEND, latching troco = credit - preco; credit < preco: compra ignored, stay ACUM.
REQ-026 compra/cancela in IDLE, VEND, REFUND: ignored.
REQ-027 VEND (one cycle): liberaProduto=1, trocoValido=1 (troco may be 0), credit cleared; -> IDLE.
REQ-028 REFUND (one cycle): trocoValido=1, troco = credit at entry, liberaProduto=0, credit cleared; -> IDLE.
REQ-029 troco SHALL hold 0 whenever trocoValido=0.
REQ-030 Inactivity counter restarts on every accepted coin; in ACUM, reaching TIMEOUT_CYCLES-1 without accepted coin -> REFUND with tempoEsgotado=1 during the REFUND cycle.
REQ-031 Counter held at 0 outside ACUM; width ceil(log2(TIMEOUT_CYCLES)).

Reset
REQ-032 reset=0 asynchronously forces IDLE, valorAcumulado=0, troco=0, counter=0, all pulse outputs 0.
REQ-033 Reset mid-VEND/REFUND discards pending credit; no pulse emitted after release.
REQ-034 First transition permitted on first clk edge after reset deasserts.

Configuration
REQ-035 Macro ACUMULADOR_TIMEOUT_EN defined: REQ-030/031 active.
REQ-036 Macro undefined: no counter logic, tempoEsgotado tied 0, credit held in ACUM indefinitely.

Verification (W=8, MAX_CREDIT=8, VAL 1/2/4, TIMEOUT_CYCLES=16, macro defined unless noted)
REQ-037 Coins 01,10,11 on consecutive cycles -> valorAcumulado 1,3,7; then code 10 -> moedaRejeitada=1, credit stays 7.
REQ-038 Credit 7, preco=6, compra -> next cycle liberaProduto=1, trocoValido=1, troco=1; following cycle valorAcumulado=0, IDLE.
REQ-039 Credit 3, preco=6, compra -> no pulses, credit 3; then cancela -> trocoValido=1, troco=3, liberaProduto=0.
REQ-040 Credit 4, no activity 15 cycles -> tempoEsgotado=1, trocoValido=1, troco=4; without macro: credit 4 after 100 cycles.
REQ-041 Same cycle cancela+compra+coin 01 at credit 2 -> REFUND troco=2, moedaRejeitada=1, no vend.
REQ-042 reset=0 between clk edges during VEND at credit 8 -> outputs 0 immediately; no pulses after release.
